// File: rtl/ecg_gate_pkg.sv
// ecg_gate_pkg: shared types and helpers for the ECG gate scheduler.
// Holds the FSM state encoding, the default counter width and a
// saturating increment used by the R-R interval counter.
package ecg_gate_pkg;

    localparam int ECG_CNT_W_DEFAULT = 24;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_BEAT = 3'd1,
        ST_DELAY     = 3'd2,
        ST_GATE      = 3'd3,
        ST_REFRACT   = 3'd4
    } ecg_state_e;

    // Increment 'value' but clamp at the all-ones value of a 'width'-bit
    // counter (width up to 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
        logic [31:0] all_ones;
        if (width >= 32) begin
            all_ones = 32'hFFFF_FFFF;
        end else begin
            all_ones = (32'd1 << width) - 32'd1;
        end
        if (value >= all_ones) begin
            return all_ones;
        end else begin
            return value + 32'd1;
        end
    endfunction

endpackage

// File: rtl/ecg_beat_event.sv
// ecg_beat_event: converts the edge detector's toggle into a one-cycle
// beat candidate, keeping only high-going (R-peak) edges. The previous
// toggle value is captured during reset so no spurious edge appears when
// reset releases. The candidate is registered so downstream logic only
// sees clean register outputs.
module ecg_beat_event
    import ecg_gate_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_toggle,
    input  logic i_level,
    output logic o_beat_cand
);

    logic r_tog_q;
    logic r_beat_cand;

    // Track the last toggle value and flag each rising-edge event for one cycle
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_tog_q     <= i_toggle;
            r_beat_cand <= 1'b0;
        end else begin
            r_tog_q     <= i_toggle;
            r_beat_cand <= (r_tog_q != i_toggle) && i_level;
        end
    end

    assign o_beat_cand = r_beat_cand;

endmodule

// File: rtl/ecg_gate_scheduler.sv
// ecg_gate_scheduler: qualifies R-peak beats, measures the R-R interval
// and sequences delay -> gate -> refractory windows for imaging triggers.
// Optional missed-beat timeout is built when ECG_GATE_TIMEOUT_EN is defined;
// without it missed_beat is tied low and timeout_cycles is ignored.
// Counter width CNT_W must be in the range 2..32.
module ecg_gate_scheduler
    import ecg_gate_pkg::*;
#(
    parameter int CNT_W         = ECG_CNT_W_DEFAULT,
    parameter bit RR_INIT_VALID = 1'b0
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             edge_toggle_in,
    input  logic             edge_state_in,
    input  logic [CNT_W-1:0] delay_cycles,
    input  logic [CNT_W-1:0] gate_len,
    input  logic [CNT_W-1:0] refract_len,
    input  logic [CNT_W-1:0] timeout_cycles,
    output logic             gate,
    output logic             beat_pulse,
    output logic             beat_ignored,
    output logic [CNT_W-1:0] rr_interval,
    output logic             rr_valid,
    output logic             missed_beat,
    output logic [2:0]       state_o
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    ecg_state_e       r_state;
    ecg_state_e       w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] r_rr_cnt;
    logic [CNT_W-1:0] w_rr_cnt_next;
    logic [CNT_W-1:0] w_rr_inc;
    logic [31:0]      w_rr_inc32;
    logic [CNT_W-1:0] r_gate_len_q;
    logic [CNT_W-1:0] r_refract_q;
    logic [CNT_W-1:0] r_rr_interval;
    logic             r_first_seen;
    logic             w_first_seen_next;
    logic             r_rr_valid;
    logic             r_gate;
    logic             w_beat_cand;
    logic             w_accept;
    logic             w_ignored;
    logic             w_timeout;
    logic             w_unused;

    ecg_beat_event u_beat_event (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_toggle    (edge_toggle_in),
        .i_level     (edge_state_in),
        .o_beat_cand (w_beat_cand)
    );

    // First non-empty phase of delay -> gate -> refractory; zero lengths are skipped.
    function automatic ecg_state_e phase_state(input logic [CNT_W-1:0] d,
                                               input logic [CNT_W-1:0] g,
                                               input logic [CNT_W-1:0] r);
        if (d != CNT_ZERO) begin
            return ST_DELAY;
        end else if (g != CNT_ZERO) begin
            return ST_GATE;
        end else if (r != CNT_ZERO) begin
            return ST_REFRACT;
        end else begin
            return ST_WAIT_BEAT;
        end
    endfunction

    // Phase counter preload: counts down to zero, so length L is loaded as L-1.
    function automatic logic [CNT_W-1:0] phase_count(input logic [CNT_W-1:0] d,
                                                     input logic [CNT_W-1:0] g,
                                                     input logic [CNT_W-1:0] r);
        if (d != CNT_ZERO) begin
            return d - CNT_ONE;
        end else if (g != CNT_ZERO) begin
            return g - CNT_ONE;
        end else if (r != CNT_ZERO) begin
            return r - CNT_ONE;
        end else begin
            return CNT_ZERO;
        end
    endfunction

    assign w_rr_inc32 = sat_inc(32'(r_rr_cnt), CNT_W);
    assign w_rr_inc   = w_rr_inc32[CNT_W-1:0];

    // A beat is accepted only while armed; anything arriving mid-window is reported and dropped.
    assign w_accept  = w_beat_cand && enable && (r_state == ST_WAIT_BEAT);
    assign w_ignored = w_beat_cand && ((r_state == ST_DELAY) || (r_state == ST_GATE) ||
                                       (r_state == ST_REFRACT));

`ifdef ECG_GATE_TIMEOUT_EN
    // Fires when the interval a beat would report this cycle reaches the limit.
    assign w_timeout = enable && (r_state == ST_WAIT_BEAT) && !w_beat_cand && r_first_seen &&
                       (timeout_cycles != CNT_ZERO) && (w_rr_inc == timeout_cycles);
    assign w_unused  = ^w_rr_inc32;
`else
    assign w_timeout = 1'b0;
    assign w_unused  = ^{w_rr_inc32, timeout_cycles};
`endif

    // Next-state and phase-counter decode; enable low overrides everything
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        if (!enable) begin
            w_next_state = ST_IDLE;
            w_cnt_next   = CNT_ZERO;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_next_state = ST_WAIT_BEAT;
                    w_cnt_next   = CNT_ZERO;
                end
                ST_WAIT_BEAT: begin
                    if (w_accept) begin
                        w_next_state = phase_state(delay_cycles, gate_len, refract_len);
                        w_cnt_next   = phase_count(delay_cycles, gate_len, refract_len);
                    end else begin
                        w_next_state = ST_WAIT_BEAT;
                        w_cnt_next   = CNT_ZERO;
                    end
                end
                ST_DELAY: begin
                    if (r_cnt == CNT_ZERO) begin
                        w_next_state = phase_state(CNT_ZERO, r_gate_len_q, r_refract_q);
                        w_cnt_next   = phase_count(CNT_ZERO, r_gate_len_q, r_refract_q);
                    end else begin
                        w_cnt_next   = r_cnt - CNT_ONE;
                    end
                end
                ST_GATE: begin
                    if (r_cnt == CNT_ZERO) begin
                        w_next_state = phase_state(CNT_ZERO, CNT_ZERO, r_refract_q);
                        w_cnt_next   = phase_count(CNT_ZERO, CNT_ZERO, r_refract_q);
                    end else begin
                        w_cnt_next   = r_cnt - CNT_ONE;
                    end
                end
                ST_REFRACT: begin
                    if (r_cnt == CNT_ZERO) begin
                        w_next_state = ST_WAIT_BEAT;
                        w_cnt_next   = CNT_ZERO;
                    end else begin
                        w_cnt_next   = r_cnt - CNT_ONE;
                    end
                end
                default: begin
                    w_next_state = ST_IDLE;
                    w_cnt_next   = CNT_ZERO;
                end
            endcase
        end
    end

    // R-R counter runs through the whole beat; cleared on accept, timeout and in IDLE
    always_comb begin
        w_rr_cnt_next     = r_rr_cnt;
        w_first_seen_next = r_first_seen;
        if ((r_state == ST_IDLE) || (w_next_state == ST_IDLE)) begin
            w_rr_cnt_next     = CNT_ZERO;
            w_first_seen_next = 1'b0;
        end else if (w_accept) begin
            w_rr_cnt_next     = CNT_ZERO;
            w_first_seen_next = 1'b1;
        end else if (w_timeout) begin
            w_rr_cnt_next     = CNT_ZERO;
            w_first_seen_next = 1'b0;
        end else begin
            w_rr_cnt_next     = w_rr_inc;
        end
    end

    // State, counters, shadow config and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= CNT_ZERO;
            r_rr_cnt      <= CNT_ZERO;
            r_first_seen  <= 1'b0;
            r_gate_len_q  <= CNT_ZERO;
            r_refract_q   <= CNT_ZERO;
            r_rr_interval <= CNT_ZERO;
            r_rr_valid    <= 1'b0;
            r_gate        <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_cnt        <= w_cnt_next;
            r_rr_cnt     <= w_rr_cnt_next;
            r_first_seen <= w_first_seen_next;
            r_gate       <= (w_next_state == ST_GATE);
            r_rr_valid   <= w_accept && (r_first_seen || RR_INIT_VALID);
            if (w_accept) begin
                // Delay goes straight into the phase counter; gate and
                // refractory lengths are held for the later phases.
                r_gate_len_q  <= gate_len;
                r_refract_q   <= refract_len;
                r_rr_interval <= w_rr_inc;
            end
        end
    end

    assign gate         = r_gate;
    assign beat_pulse   = w_accept;
    assign beat_ignored = w_ignored;
    assign rr_interval  = r_rr_interval;
    assign rr_valid     = r_rr_valid;
    assign missed_beat  = w_timeout;
    assign state_o      = r_state;

endmodule

// File: tb/tb_ecg_gate_scheduler.sv
// tb_ecg_gate_scheduler: directed self-checking bench for ecg_gate_scheduler.
// Cycle N is the cycle in which beat_pulse is seen; outputs are sampled 1ns
// after each rising clock edge and inputs are driven right after sampling.
module tb_ecg_gate_scheduler;

    localparam int CNT_W = 24;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic             edge_toggle_in;
    logic             edge_state_in;
    logic [CNT_W-1:0] delay_cycles;
    logic [CNT_W-1:0] gate_len;
    logic [CNT_W-1:0] refract_len;
    logic [CNT_W-1:0] timeout_cycles;
    logic             gate;
    logic             beat_pulse;
    logic             beat_ignored;
    logic [CNT_W-1:0] rr_interval;
    logic             rr_valid;
    logic             missed_beat;
    logic [2:0]       state_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ecg_gate_scheduler #(.CNT_W(CNT_W), .RR_INIT_VALID(1'b0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .edge_toggle_in (edge_toggle_in),
        .edge_state_in  (edge_state_in),
        .delay_cycles   (delay_cycles),
        .gate_len       (gate_len),
        .refract_len    (refract_len),
        .timeout_cycles (timeout_cycles),
        .gate           (gate),
        .beat_pulse     (beat_pulse),
        .beat_ignored   (beat_ignored),
        .rr_interval    (rr_interval),
        .rr_valid       (rr_valid),
        .missed_beat    (missed_beat),
        .state_o        (state_o)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_edge(input logic level);
        edge_toggle_in = ~edge_toggle_in;
        edge_state_in  = level;
    endtask

    task automatic set_cfg(input int d, input int g, input int r);
        delay_cycles = CNT_W'(d);
        gate_len     = CNT_W'(g);
        refract_len  = CNT_W'(r);
    endtask

    initial begin
        int stray;
        int gate_hits;
        int misses;
        int first_miss;

        rst_n          = 1'b0;
        enable         = 1'b0;
        edge_toggle_in = 1'b0;
        edge_state_in  = 1'b1;
        timeout_cycles = CNT_W'(0);
        set_cfg(0, 0, 0);

        // Reset, with the toggle input moving to 1 during reset
        step();
        step();
        edge_toggle_in = 1'b1;
        step();
        rst_n = 1'b1;
        check_val("rst_state", 32'(state_o), 32'd0);
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (beat_pulse || beat_ignored || gate || rr_valid || missed_beat) stray++;
        end
        check_val("rst_quiet", 32'(stray), 32'd0);
        check_val("rst_state10", 32'(state_o), 32'd0);
        check_val("rst_rr", 32'(rr_interval), 32'd0);

        // Enable, then first beat with delay=5 gate=3 refract=4
        enable = 1'b1;
        step();
        check_val("en_wait", 32'(state_o), 32'd1);
        set_cfg(5, 3, 4);
        drive_edge(1'b1);
        step();
        check_val("b1_pulse", 32'(beat_pulse), 32'd1);
        check_val("b1_state_n", 32'(state_o), 32'd1);
        for (int k = 1; k <= 14; k++) begin
            step();
            check_val("b1_gate", 32'(gate), 32'((k >= 6) && (k <= 8)));
            if (k == 1)  check_val("b1_no_rrv", 32'(rr_valid), 32'd0);
            if (k == 5)  check_val("b1_delay", 32'(state_o), 32'd2);
            if (k == 6)  check_val("b1_gate_st", 32'(state_o), 32'd3);
            if (k == 12) check_val("b1_refract", 32'(state_o), 32'd4);
            if (k == 13) check_val("b1_back", 32'(state_o), 32'd1);
        end

        // Low-going edges in between, second beat 1000 cycles after the first
        stray = 0;
        for (int k = 15; k <= 999; k++) begin
            step();
            if (beat_pulse || beat_ignored || rr_valid) stray++;
            if ((k == 300) || (k == 600)) drive_edge(1'b0);
            if (k == 999) drive_edge(1'b1);
        end
        check_val("low_edges_quiet", 32'(stray), 32'd0);
        step();
        check_val("b2_pulse", 32'(beat_pulse), 32'd1);
        for (int k = 1; k <= 14; k++) begin
            step();
            check_val("b2_gate", 32'(gate), 32'((k >= 6) && (k <= 8)));
            if (k == 1) begin
                check_val("b2_rrv", 32'(rr_valid), 32'd1);
                check_val("b2_rr", 32'(rr_interval), 32'd1000);
            end
            if (k == 2) check_val("b2_rrv_once", 32'(rr_valid), 32'd0);
            if (k == 3) set_cfg(0, 0, 0);
            if (k == 6) drive_edge(1'b1);
            if (k == 7) begin
                check_val("gate_beat_ign", 32'(beat_ignored), 32'd1);
                check_val("gate_beat_nopulse", 32'(beat_pulse), 32'd0);
                check_val("gate_beat_state", 32'(state_o), 32'd3);
            end
            if (k == 8)  check_val("gate_beat_norrv", 32'(rr_valid), 32'd0);
            if (k == 13) check_val("b2_back", 32'(state_o), 32'd1);
        end

        // All-zero config: beat accepted, stays in WAIT_BEAT, no gate
        for (int k = 15; k <= 19; k++) begin
            step();
            if (k == 19) drive_edge(1'b1);
        end
        step();
        check_val("b3_pulse", 32'(beat_pulse), 32'd1);
        gate_hits = 0;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (gate) gate_hits++;
            check_val("b3_wait", 32'(state_o), 32'd1);
            if (k == 1) begin
                check_val("b3_rrv", 32'(rr_valid), 32'd1);
                check_val("b3_rr", 32'(rr_interval), 32'd20);
            end
        end
        check_val("b3_no_gate", 32'(gate_hits), 32'd0);

        // Enable dropped at the 2nd gate cycle (delay=2 gate=4 refract=3)
        set_cfg(2, 4, 3);
        drive_edge(1'b1);
        step();
        check_val("b4_pulse", 32'(beat_pulse), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            step();
            check_val("b4_gate", 32'(gate), 32'(k >= 3));
            if (k == 1) check_val("b4_rr", 32'(rr_interval), 32'd7);
        end
        enable = 1'b0;
        step();
        check_val("drop_gate", 32'(gate), 32'd0);
        check_val("drop_state", 32'(state_o), 32'd0);
        step();
        check_val("drop_gate2", 32'(gate), 32'd0);

        // Re-enable: first beat after IDLE gives no rr_valid; timeout window
        timeout_cycles = CNT_W'(200);
        enable = 1'b1;
        step();
        check_val("reen_wait", 32'(state_o), 32'd1);
        for (int k = 2; k <= 5; k++) begin
            step();
            if (k == 5) drive_edge(1'b1);
        end
        step();
        check_val("reen_pulse", 32'(beat_pulse), 32'd1);
        step();
        check_val("reen_no_rrv", 32'(rr_valid), 32'd0);
        check_val("reen_rr", 32'(rr_interval), 32'd6);
        misses = 0;
        first_miss = -1;
        for (int k = 2; k <= 260; k++) begin
            step();
            if (missed_beat) begin
                misses++;
                if (first_miss < 0) first_miss = k;
            end
        end
`ifdef ECG_GATE_TIMEOUT_EN
        check_val("timeout_count", 32'(misses), 32'd1);
        check_val("timeout_cycle", 32'(first_miss), 32'd200);
`else
        check_val("no_timeout", 32'(misses), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
